vga_rect_overlay: RTL and testbench

- Parametrised successor to the fixed single-red-rectangle VGA demo.
- Generates VGA timing from generic porch/sync parameters and overlays RECTS independently programmable, coloured, priority-ordered rectangles on a background colour.
- Host writes go to shadow registers and are committed atomically at the frame boundary (tear-free).
- Sits directly behind the clock manager; clock must equal the pixel clock.

---
 rtl/vga_rect_overlay.sv | 172 +++++++++++++++++
 tb/tb_vga_rect_overlay.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_overlay.sv
// rtl/vga_rect_overlay.sv - VGA timing generator with shadowed, priority-ordered rectangle overlay
// Optional feature macro: RECT_OUTLINE_EN (adds cfg_outline and outline-only rectangles)
module vga_rect_overlay #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    parameter int RECTS     = 4,
    parameter int CW        = 1,
    parameter int XW        = 10,
    localparam int IW       = (RECTS > 1) ? $clog2(RECTS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [XW-1:0]   cfg_x0,
    input  logic [XW-1:0]   cfg_y0,
    input  logic [XW-1:0]   cfg_x1,
    input  logic [XW-1:0]   cfg_y1,
    input  logic [3*CW-1:0] cfg_rgb,
    input  logic            cfg_en,
`ifdef RECT_OUTLINE_EN
    input  logic            cfg_outline,
`endif
    input  logic [3*CW-1:0] bg_rgb,
    output logic            vga_hsync,
    output logic            vga_vsync,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b,
    output logic            frame_start
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic SYNC_ACT = (SYNC_POL != 0);
    localparam logic [IW:0] RECT_CNT = (IW+1)'(RECTS);

    typedef struct packed {
        logic            en;
        logic [XW-1:0]   x0;
        logic [XW-1:0]   y0;
        logic [XW-1:0]   x1;
        logic [XW-1:0]   y1;
        logic [3*CW-1:0] rgb;
    } rect_t;

    logic [XW-1:0]   hcnt, vcnt;
    logic            commit, idx_ok, hs_on, vs_on;
    rect_t           shadow [RECTS];
    rect_t           active [RECTS];
    logic [RECTS-1:0] hit, hit_s1;
    logic            vis_s1, hs_s1, vs_s1, hs_s2, vs_s2;
    logic [3*CW-1:0] pix, rgb_s2;
`ifdef RECT_OUTLINE_EN
    logic [RECTS-1:0] shadow_ol, active_ol;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (int'(hcnt) == H_TOTAL - 1) begin
            hcnt <= '0;
            if (int'(vcnt) == V_TOTAL - 1)
                vcnt <= '0;
            else
                vcnt <= vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Commit on the first blanking line so the whole visible frame uses one set.
    assign commit      = (hcnt == '0) && (int'(vcnt) == V_VISIBLE);
    assign frame_start = commit;
    assign idx_ok      = ({1'b0, cfg_idx} < RECT_CNT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RECTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
`ifdef RECT_OUTLINE_EN
            shadow_ol <= '0;
            active_ol <= '0;
`endif
        end else begin
            if (commit) begin
                for (int i = 0; i < RECTS; i++)
                    active[i] <= shadow[i];
`ifdef RECT_OUTLINE_EN
                active_ol <= shadow_ol;
`endif
            end
            if (cfg_we && idx_ok) begin
                shadow[cfg_idx] <= '{en: cfg_en, x0: cfg_x0, y0: cfg_y0,
                                     x1: cfg_x1, y1: cfg_y1, rgb: cfg_rgb};
`ifdef RECT_OUTLINE_EN
                shadow_ol[cfg_idx] <= cfg_outline;
`endif
            end
        end
    end

    // An inverted rectangle (x0>x1 or y0>y1) can never satisfy both bounds.
    always_comb begin
        hit = '0;
        for (int i = 0; i < RECTS; i++) begin
            hit[i] = active[i].en
                  && (hcnt >= active[i].x0) && (hcnt <= active[i].x1)
                  && (vcnt >= active[i].y0) && (vcnt <= active[i].y1)
`ifdef RECT_OUTLINE_EN
                  && (!active_ol[i] || (hcnt == active[i].x0) || (hcnt == active[i].x1)
                      || (vcnt == active[i].y0) || (vcnt == active[i].y1))
`endif
                  ;
        end
    end

    assign hs_on = (int'(hcnt) >= HS_START) && (int'(hcnt) < HS_END);
    assign vs_on = (int'(vcnt) >= VS_START) && (int'(vcnt) < VS_END);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_s1 <= '0;
            vis_s1 <= 1'b0;
            hs_s1  <= ~SYNC_ACT;
            vs_s1  <= ~SYNC_ACT;
        end else begin
            hit_s1 <= hit;
            vis_s1 <= (int'(hcnt) < H_VISIBLE) && (int'(vcnt) < V_VISIBLE);
            hs_s1  <= hs_on ? SYNC_ACT : ~SYNC_ACT;
            vs_s1  <= vs_on ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    always_comb begin
        pix = bg_rgb;
        for (int i = RECTS - 1; i >= 0; i--)
            if (hit_s1[i]) pix = active[i].rgb;
        if (!vis_s1) pix = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_s2 <= '0;
            hs_s2  <= ~SYNC_ACT;
            vs_s2  <= ~SYNC_ACT;
        end else begin
            rgb_s2 <= pix;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
        end
    end

    assign vga_hsync = hs_s2;
    assign vga_vsync = vs_s2;
    assign vga_r     = rgb_s2[3*CW-1 -: CW];
    assign vga_g     = rgb_s2[2*CW-1 -: CW];
    assign vga_b     = rgb_s2[CW-1 -: CW];
endmodule

// File: tb/tb_vga_rect_overlay.sv
// tb/tb_vga_rect_overlay.sv - self-checking bench for vga_rect_overlay (reduced raster)
module tb_vga_rect_overlay;
    localparam int HV = 48, HF = 4, HS = 6, HB = 6;
    localparam int VV = 24, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB, FR = HT * VT;
    localparam int RECTS = 3, XW = 8;

    logic clock = 1'b0, reset = 1'b0;
    logic cfg_we = 1'b0, cfg_en = 1'b0, cfg_outline = 1'b0, cur_ol;
    logic [1:0] cfg_idx = '0;
    logic [XW-1:0] cfg_x0 = '0, cfg_y0 = '0, cfg_x1 = '0, cfg_y1 = '0;
    logic [2:0] cfg_rgb = '0, bg_rgb = '0;
    logic vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_start;
    wire [2:0] rgb_out = {vga_r, vga_g, vga_b};

`ifdef RECT_OUTLINE_EN
    assign cur_ol = cfg_outline;
`else
    assign cur_ol = 1'b0;
`endif

    vga_rect_overlay #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(0), .RECTS(RECTS), .CW(1), .XW(XW)
    ) dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_x1(cfg_x1), .cfg_y1(cfg_y1),
        .cfg_rgb(cfg_rgb), .cfg_en(cfg_en),
`ifdef RECT_OUTLINE_EN
        .cfg_outline(cfg_outline),
`endif
        .bg_rgb(bg_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: raster position from edge count, rectangles by plain geometry.
    typedef struct { bit en; bit ol; int x0; int y0; int x1; int y1; bit [2:0] rgb; } mrect_t;
    typedef struct { int sel; bit [2:0] rgb; bit hs; bit vs; } stage_t;
    mrect_t shadow_m [RECTS];
    mrect_t active_m [RECTS];
    stage_t e1, e2;
    int n = 0, bad = 0;

    function automatic stage_t idle();
        stage_t s;
        s.sel = -2; s.rgb = 3'b000; s.hs = 1'b1; s.vs = 1'b1;
        return s;
    endfunction

    function automatic bit covers(mrect_t r, int h, int v);
        bit in_box = r.en && h >= r.x0 && h <= r.x1 && v >= r.y0 && v <= r.y1;
        if (r.ol) return in_box && (h == r.x0 || h == r.x1 || v == r.y0 || v == r.y1);
        return in_box;
    endfunction

    function automatic stage_t look(int h, int v);
        stage_t s = idle();
        s.hs = !(h >= HV + HF && h < HV + HF + HS);
        s.vs = !(v >= VV + VF && v < VV + VF + VS);
        if (h < HV && v < VV) begin
            s.sel = -1;
            for (int i = RECTS - 1; i >= 0; i--)
                if (covers(active_m[i], h, v)) begin s.sel = i; s.rgb = active_m[i].rgb; end
        end
        return s;
    endfunction

    function automatic stage_t fin(stage_t s, bit [2:0] bg);
        stage_t o = s;
        if (s.sel == -1) o.rgb = bg;
        else if (s.sel == -2) o.rgb = 3'b000;
        return o;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            n <= 0; e1 <= idle(); e2 <= idle();
            for (int i = 0; i < RECTS; i++) begin
                shadow_m[i] <= '{default: 0};
                active_m[i] <= '{default: 0};
            end
        end else begin
            e1 <= look(n % HT, (n / HT) % VT);
            e2 <= fin(e1, bg_rgb);
            if (n % HT == 0 && (n / HT) % VT == VV)
                for (int i = 0; i < RECTS; i++) active_m[i] <= shadow_m[i];
            if (cfg_we && cfg_idx < RECTS)
                shadow_m[cfg_idx] <= '{en: cfg_en, ol: cur_ol, x0: int'(cfg_x0), y0: int'(cfg_y0),
                                       x1: int'(cfg_x1), y1: int'(cfg_y1), rgb: cfg_rgb};
            n <= n + 1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            if (rgb_out !== e2.rgb || vga_hsync !== e2.hs || vga_vsync !== e2.vs
                || frame_start !== (n % HT == 0 && (n / HT) % VT == VV))
                bad++;
            if (n % HT == 0 && (n / HT) % VT == VV) begin
                check("frame_model_mismatches", bad, 0);
                bad = 0;
            end
        end
    end

    task automatic wr(input int idx, input int x0, input int y0, input int x1, input int y1,
                      input bit [2:0] rgb, input bit en, input bit ol);
        @(negedge clock);
        cfg_idx = 2'(idx); cfg_x0 = XW'(x0); cfg_y0 = XW'(y0); cfg_x1 = XW'(x1); cfg_y1 = XW'(y1);
        cfg_rgb = rgb; cfg_en = en; cfg_outline = ol; cfg_we = 1'b1;
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    task automatic wait_fs();
        int k = 0;
        do begin @(negedge clock); k++; end while (!frame_start && k < 2 * FR);
        check("frame_start_seen", frame_start, 1);
    endtask

    task automatic wait_pos(input int x, input int y);
        int k = 0;
        do begin @(negedge clock); k++; end
        while (!(n >= 2 && (n - 2) % HT == x && ((n - 2) / HT) % VT == y) && k < 2 * FR);
        if (k >= 2 * FR) check("wait_pos_timeout", k, 0);
    endtask

    int cnt [8];
    task automatic count_frame();
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int k = 0; k < FR; k++) begin
            @(negedge clock);
            cnt[rgb_out]++;
        end
    endtask

    typedef struct { int scene; int x; int y; logic [2:0] rgb; } probe_t;
    probe_t probes[$];

    task automatic run_probes(input int scene);
        foreach (probes[i])
            if (probes[i].scene == scene) begin
                wait_pos(probes[i].x, probes[i].y);
                check($sformatf("probe s%0d (%0d,%0d)", scene, probes[i].x, probes[i].y),
                      rgb_out, probes[i].rgb);
            end
    endtask

    initial begin
        int t, w, h;
        // raster order within each scene
        probes.push_back('{0, 9, 5, 3'b000});   probes.push_back('{0, 10, 5, 3'b100});
        probes.push_back('{0, 19, 14, 3'b100}); probes.push_back('{0, 20, 14, 3'b000});
        probes.push_back('{0, 10, 15, 3'b000});
        probes.push_back('{1, 2, 2, 3'b010});   probes.push_back('{1, 55, 2, 3'b000});
        probes.push_back('{1, 8, 8, 3'b100});   probes.push_back('{1, 10, 10, 3'b100});
        probes.push_back('{1, 11, 11, 3'b001}); probes.push_back('{1, 16, 16, 3'b001});
        probes.push_back('{1, 17, 16, 3'b010}); probes.push_back('{1, 43, 20, 3'b010});
        probes.push_back('{1, 44, 20, 3'b111}); probes.push_back('{1, 47, 23, 3'b111});
        probes.push_back('{1, 48, 23, 3'b000});
        probes.push_back('{2, 20, 14, 3'b100}); probes.push_back('{2, 24, 16, 3'b100});
        probes.push_back('{3, 20, 5, 3'b000});  probes.push_back('{3, 24, 5, 3'b000});
        probes.push_back('{3, 25, 5, 3'b100});  probes.push_back('{3, 29, 20, 3'b100});
        probes.push_back('{3, 30, 20, 3'b000});

        bg_rgb = 3'b011;
        repeat (3) @(negedge clock);
        check("reset_rgb", rgb_out, 0);
        check("reset_hsync", vga_hsync, 1);
        check("reset_vsync", vga_vsync, 1);
        check("reset_frame_start", frame_start, 0);
        reset = 1'b1;
        @(negedge clock); check("release_edge1_rgb", rgb_out, 0);
        @(negedge clock); check("release_edge2_rgb", rgb_out, 3'b011);

        t = 2;
        while (vga_hsync === 1'b1 && t < 4 * HT) begin @(negedge clock); t++; end
        check("hsync_first_fall", t, HV + HF + 2);
        w = 0; while (vga_hsync === 1'b0 && w < 2 * HT) begin @(negedge clock); w++; end
        check("hsync_width", w, HS);
        h = 0; while (vga_hsync === 1'b1 && h < 2 * HT) begin @(negedge clock); h++; end
        check("hsync_period", w + h, HT);
        t = 0; while (vga_vsync === 1'b1 && t < 2 * FR) begin @(negedge clock); t++; end
        w = 0; while (vga_vsync === 1'b0 && w < 2 * FR) begin @(negedge clock); w++; end
        check("vsync_width", w, VS * HT);
        h = 0; while (vga_vsync === 1'b1 && h < 2 * FR) begin @(negedge clock); h++; end
        check("vsync_period", w + h, FR);

        bg_rgb = 3'b000;
        wr(0, 10, 5, 19, 14, 3'b100, 1, 0);
        wait_fs(); count_frame();
        check("single_red_pixels", cnt[4], 100);
        check("single_black_pixels", cnt[0], FR - 100);
        run_probes(0);

        bg_rgb = 3'b010;
        wr(0, 4, 4, 10, 10, 3'b100, 1, 0);
        wr(1, 8, 8, 16, 16, 3'b001, 1, 0);
        wr(2, 44, 20, 80, 40, 3'b111, 1, 0);
        wait_fs(); count_frame();
        check("prio_red", cnt[4], 49);
        check("prio_blue", cnt[1], 72);
        check("prio_clipped_white", cnt[7], 16);
        check("prio_bg", cnt[2], HV * VV - 49 - 72 - 16);
        run_probes(1);

        wr(2, 50, 0, 40, 23, 3'b111, 1, 0);
        wr(3, 0, 0, 255, 255, 3'b111, 1, 0);
        wait_fs(); count_frame();
        check("empty_and_bad_idx_white", cnt[7], 0);
        check("bad_idx_red_kept", cnt[4], 49);

        bg_rgb = 3'b000;
        wr(1, 0, 0, 0, 0, 3'b000, 0, 0);
        wr(2, 0, 0, 0, 0, 3'b000, 0, 0);
        wr(0, 20, 5, 29, 20, 3'b100, 1, 0);
        wait_fs();
        wait_pos(0, 12);
        wr(0, 25, 5, 29, 20, 3'b100, 1, 0);
        run_probes(2);
        run_probes(3);

`ifdef RECT_OUTLINE_EN
        wr(0, 10, 5, 19, 14, 3'b100, 1, 1);
        wait_fs(); count_frame();
        check("outline_red_pixels", cnt[4], 36);
`endif

        for (int f = 0; f < 4; f++) begin
            bg_rgb = 3'($urandom);
            for (int k = 0; k < 3; k++) begin
                repeat ($urandom_range(1, 500)) @(negedge clock);
                wr($urandom_range(0, 3), $urandom_range(0, 70), $urandom_range(0, 35),
                   $urandom_range(0, 70), $urandom_range(0, 35), 3'($urandom),
                   $urandom_range(0, 3) != 0, 1'($urandom));
            end
            wait_fs();
        end

        bg_rgb = 3'b110;
        wait_pos(3, 15);
        #2 reset = 1'b0;
        #1;
        check("midreset_rgb", rgb_out, 0);
        check("midreset_hsync", vga_hsync, 1);
        check("midreset_vsync", vga_vsync, 1);
        check("midreset_frame_start", frame_start, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock); check("midreset_edge1_rgb", rgb_out, 0);
        @(negedge clock); check("midreset_edge2_rgb", rgb_out, 3'b110);
        wait_fs(); count_frame();
        check("midreset_all_bg", cnt[6], HV * VV);
        check("midreset_black", cnt[0], FR - HV * VV);

        check("frame_model_tail", bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
